mat_result_streamer: RTL
========================

// Module: mat_result_streamer
// PURPOSE
//  Reader end of the mat_mul result interface. Captures a full N x N result
//  matrix on the single-cycle valid pulse from mat_mul. mat_mul has no ready
//  input, so the block buffers up to two matrices (ping-pong). It drains them
//  one row per beat over a valid/ready stream toward the writeback path.
// PARAMETERS
//  W_OUT  32  width of one result element (signed)
//  N      8   matrix dimension; rows per matrix and elements per beat
// PORTS
//  clk        in   1            rising-edge clock
//  rstn       in   1            asynchronous active-low reset
//  cen        in   1            clock enable; 0 freezes all state
//  valid_in   in   1            one-cycle pulse; result_in holds a full matrix
//  result_in  in   N*N*W_OUT    signed [W_OUT-1:0] result_in [N][N] from mat_mul
//  m_ready    in   1            downstream accepts the current beat
//  m_valid    out  1            m_data holds a valid row
//  m_data     out  N*W_OUT      signed [W_OUT-1:0] m_data [N]: row m_row of head matrix
//  m_row      out  $clog2(N)    index of the row on m_data
//  m_last     out  1            high on row N-1 of each matrix
//  busy       out  1            at least one buffer slot occupied
//  overflow   out  1            sticky; a capture was dropped because both slots were full
// BEHAVIOUR
//  Reset (async, rstn=0):
//   - all outputs 0; slots empty; wr_ptr=rd_ptr=0; row_cnt=0; overflow=0.
//   - Reset mid-stream discards both slots. No beat is emitted after release until a new capture.
//  Occupancy cnt in {0,1,2}. A slot has states EMPTY and FULL. Read side states:
//   - IDLE (cnt==0).
//   - STREAM (cnt>0).
//  Capture, at the edge with cen=1 and valid_in=1:
//   - If cnt<2, or cnt==2 and the final beat of the head matrix completes that same edge:
//     write result_in to slot[wr_ptr], mark it FULL, toggle wr_ptr.
//   - Otherwise drop the matrix, set overflow=1 (held until reset), leave state unchanged.
//  Output:
//   - m_valid = cen & (cnt>0).
//   - m_data = slot[rd_ptr][row_cnt]; m_row = row_cnt; m_last = m_valid & (row_cnt==N-1).
//   - Outputs decode from registered state only; no combinational path from valid_in/result_in.
//  Handshake:
//   - Beat completes at an edge with m_valid & m_ready. row_cnt increments.
//   - At row N-1: row_cnt wraps to 0, slot[rd_ptr] goes EMPTY, rd_ptr toggles.
//   - m_data/m_row stay stable while m_valid=1 and m_ready=0.
//  Latency: capture at edge k into an empty block gives m_valid=1 in cycle k+1.
//   - Full matrix drains in N beats minimum (m_ready held high).
//  Simultaneous capture and final beat with cnt==1: cnt stays 1, new matrix becomes head.
//  Simultaneous capture and final beat with cnt==2: capture accepted, no overflow.
//  cen=0: no capture, no beat, m_valid=0; valid_in pulses during cen=0 are ignored.
//  Arithmetic: no arithmetic on data; elements pass bit-exact and signed.
//  busy = (cnt>0).
// STRUCTURE
//  - mat_pkg (shared with mat_mul and its loader):
//     - W_IN, W_OUT, N defaults
//     - typedef row_t (signed [W_OUT-1:0] [N])
//     - typedef mat_t (row_t [N])
//  - Single module, no sub-module. Storage: mat_t slot[2], slot_full[2], wr_ptr, rd_ptr,
//    row_cnt, overflow.
// TESTING (N=8, W_OUT=32; bench reuses the mat_mul reference model)
//  - Reset: rstn=0 mid-stream with cnt=2 -> m_valid=0, busy=0, overflow=0.
//    After release, no beats until the next valid_in.
//  - Single matrix, m_ready=1: capture A where A[r][c]=r*8+c at edge k -> m_valid from k+1.
//    8 beats with m_row 0..7 and m_data[c]=r*8+c; m_last only on beat 8; busy=0 after.
//  - Backpressure: m_ready toggles 1,0,0,1,... -> each row is emitted exactly once and held stable
//    while stalled; rows arrive in order; matrix holds negative values (-2^31, -1) bit-exact.
//  - Ping-pong: capture A, then B 2 cycles later, m_ready=1 -> 16 beats: A rows 0..7 then
//    B rows 0..7, no gap between m_last of A and row 0 of B.
//  - Overflow: m_ready=0; capture A, B, C -> C dropped, overflow=1 sticky.
//    Release m_ready -> A, then B streamed; overflow still 1.
//  - Boundary: cnt=2, valid_in in the same cycle as A's last beat -> capture D accepted.
//    overflow=0; stream is B then D.
//  - cen gating: cen=0 with valid_in=1 and m_ready=1 -> no capture, m_valid=0.
//    Row counter frozen mid-matrix, resumes at the same row when cen=1.

Source files
------------

// File: rtl/mat_pkg.sv
// Shared definitions for mat_mul, its loader and the result streamer.
// Element widths, matrix dimension defaults and the row/matrix container types.
package mat_pkg;

  localparam int unsigned DEF_W_IN  = 16;
  localparam int unsigned DEF_W_OUT = 32;
  localparam int unsigned DEF_N     = 8;

  typedef logic signed [DEF_N-1:0][DEF_W_OUT-1:0] row_t;
  typedef row_t [DEF_N-1:0] mat_t;

  typedef enum logic {StIdle, StStream} rd_state_e;

endpackage

// File: rtl/mat_result_streamer.sv
// Captures whole result matrices from mat_mul into a two-slot ping-pong buffer
// and drains them one row per beat over a valid/ready stream.
module mat_result_streamer
  import mat_pkg::*;
#(
  parameter int unsigned W_OUT = DEF_W_OUT,
  parameter int unsigned N     = DEF_N,
  localparam int unsigned RW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                cen,
  input  logic                                valid_in,
  input  logic signed [N-1:0][N-1:0][W_OUT-1:0] result_in,
  input  logic                                m_ready,
  output logic                                m_valid,
  output logic signed [N-1:0][W_OUT-1:0]      m_data,
  output logic [RW-1:0]                       m_row,
  output logic                                m_last,
  output logic                                busy,
  output logic                                overflow
);

  typedef logic signed [N-1:0][W_OUT-1:0] row_lt;
  typedef row_lt [N-1:0] mat_lt;

  localparam logic [RW-1:0] LastRow = RW'(N - 1);

  mat_lt         slot_q [2];
  mat_lt         slot_d [2];
  logic [1:0]    full_q, full_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [RW-1:0] row_q, row_d;
  logic          ovf_q, ovf_d;
  rd_state_e     st_q, st_d;

  logic beat, last_beat, accept;

  always_comb begin
    slot_d    = slot_q;
    full_d    = full_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    row_d     = row_q;
    ovf_d     = ovf_q;

    beat      = cen & (st_q == StStream) & m_ready;
    last_beat = beat & (row_q == LastRow);
    // A full buffer can still take a capture if the head frees its slot this edge.
    accept    = cen & valid_in & (~(&full_q) | last_beat);

    if (beat) begin
      row_d = last_beat ? '0 : row_q + RW'(1);
    end
    if (last_beat) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ~rd_ptr_q;
    end
    if (accept) begin
      slot_d[wr_ptr_q] = result_in;
      full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (cen & valid_in & ~accept) begin
      ovf_d = 1'b1;
    end

    st_d = (full_d != 2'b00) ? StStream : StIdle;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      full_q    <= 2'b00;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      row_q     <= '0;
      ovf_q     <= 1'b0;
      st_q      <= StIdle;
    end else begin
      slot_q    <= slot_d;
      full_q    <= full_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      row_q     <= row_d;
      ovf_q     <= ovf_d;
      st_q      <= st_d;
    end
  end

  assign m_valid  = cen & (st_q == StStream);
  assign m_data   = slot_q[rd_ptr_q][row_q];
  assign m_row    = row_q;
  assign m_last   = m_valid & (row_q == LastRow);
  assign busy     = (st_q == StStream);
  assign overflow = ovf_q;

endmodule
